// File: rtl/vga_pkg.sv
// Shared VGA timing, framebuffer geometry and colour encodings for the scanout
// and the drawing datapath.
package vga_pkg;
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int FB_W        = 160;
    localparam int FB_H        = 120;
    localparam int SCALE_SHIFT = 2;
    localparam int ADDR_W      = 15;
    localparam int CNT_W       = 10;
    localparam int DAC_W       = 10;

    typedef logic [2:0] colour_t;
    localparam colour_t BLACK   = 3'b000;
    localparam colour_t BLUE    = 3'b001;
    localparam colour_t GREEN   = 3'b010;
    localparam colour_t CYAN    = 3'b011;
    localparam colour_t RED     = 3'b100;
    localparam colour_t MAGENTA = 3'b101;
    localparam colour_t YELLOW  = 3'b110;
    localparam colour_t WHITE   = 3'b111;

    // y*160 + x with shifts only; counters are divided by the 4x scale first
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [CNT_W-1:0] h,
                                                  input logic [CNT_W-1:0] v);
        logic [ADDR_W-1:0] fx;
        logic [ADDR_W-1:0] fy;
        fx = ADDR_W'(h >> SCALE_SHIFT);
        fy = ADDR_W'(v >> SCALE_SHIFT);
        return (fy << 7) + (fy << 5) + fx;
    endfunction
endpackage

// File: rtl/vga_scanout_if.sv
// Framebuffer read port plus DAC/sync pins; master is the scanout side.
interface vga_scanout_if;
    import vga_pkg::*;
    logic [ADDR_W-1:0] rd_addr;
    logic [2:0]        rd_data;
    logic [DAC_W-1:0]  VGA_R;
    logic [DAC_W-1:0]  VGA_G;
    logic [DAC_W-1:0]  VGA_B;
    logic              VGA_HS;
    logic              VGA_VS;
    logic              VGA_BLANK;
    logic              VGA_SYNC;
    logic              VGA_CLK;
    logic              vblank_start;

    modport master (
        output rd_addr, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS,
               VGA_BLANK, VGA_SYNC, VGA_CLK, vblank_start,
        input  rd_data
    );
    modport slave (
        input  rd_addr, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS,
               VGA_BLANK, VGA_SYNC, VGA_CLK, vblank_start,
        output rd_data
    );
endinterface

// File: rtl/vga_timing.sv
// Pixel-rate divider, raster counters and stage-0 decode (active, syncs).
// Decodes are combinational from the counters; free-running, no backpressure.
module vga_timing import vga_pkg::*; #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic             clk,
    input  logic             reset,
    output logic             pix_en,
    output logic             pix_clk,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             active,
    output logic             hs_n,
    output logic             vs_n,
    output logic             vblank_start
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [DIV_W-1:0] div;
    logic             h_end;
    logic             v_end;

    assign pix_en  = (div == DIV_W'(CLK_DIV - 1));
    assign pix_clk = (div >= DIV_W'(CLK_DIV / 2));
    assign h_end   = (h_cnt == CNT_W'(H_TOT - 1));
    assign v_end   = (v_cnt == CNT_W'(V_TOT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div          <= '0;
            h_cnt        <= '0;
            v_cnt        <= '0;
            vblank_start <= 1'b0;
        end else begin
            // fires as v_cnt steps onto the first non-visible line
            vblank_start <= pix_en && h_end && (v_cnt == CNT_W'(V_ACTIVE - 1));
            if (pix_en) begin
                div <= '0;
                if (h_end) begin
                    h_cnt <= '0;
                    v_cnt <= v_end ? '0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end else begin
                div <= div + 1'b1;
            end
        end
    end

    assign active = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));
    assign hs_n   = !((h_cnt >= CNT_W'(H_ACTIVE + H_FP)) &&
                      (h_cnt <  CNT_W'(H_ACTIVE + H_FP + H_SYNC)));
    assign vs_n   = !((v_cnt >= CNT_W'(V_ACTIVE + V_FP)) &&
                      (v_cnt <  CNT_W'(V_ACTIVE + V_FP + V_SYNC)));
endmodule

// File: rtl/vga_scanout.sv
// Framebuffer scanout to VGA DAC: 160x120 read back 4x-scaled into 640x480@60.
// Counter-to-pin latency is 2 pixel ticks for colour, sync and blank alike; no backpressure.
module vga_scanout import vga_pkg::*; #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic          clk,
    input  logic          reset,
    vga_scanout_if.master vga
);
    logic             pix_en;
    logic             pix_clk;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             active;
    logic             hs_n;
    logic             vs_n;
    logic             vblank;
    logic             active1;
    logic             hs1;
    logic             vs1;

    vga_timing #(
        .CLK_DIV (CLK_DIV),
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk         (clk),
        .reset       (reset),
        .pix_en      (pix_en),
        .pix_clk     (pix_clk),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .active      (active),
        .hs_n        (hs_n),
        .vs_n        (vs_n),
        .vblank_start(vblank)
    );

    // The RAM answers one clk after rd_addr, always before the next pix_en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga.rd_addr   <= '0;
            active1       <= 1'b0;
            hs1           <= 1'b1;
            vs1           <= 1'b1;
            vga.VGA_R     <= '0;
            vga.VGA_G     <= '0;
            vga.VGA_B     <= '0;
            vga.VGA_HS    <= 1'b1;
            vga.VGA_VS    <= 1'b1;
            vga.VGA_BLANK <= 1'b0;
        end else if (pix_en) begin
            vga.rd_addr   <= active ? fb_addr(h_cnt, v_cnt) : '0;
            active1       <= active;
            hs1           <= hs_n;
            vs1           <= vs_n;
            vga.VGA_R     <= {DAC_W{vga.rd_data[2] & active1}};
            vga.VGA_G     <= {DAC_W{vga.rd_data[1] & active1}};
            vga.VGA_B     <= {DAC_W{vga.rd_data[0] & active1}};
            vga.VGA_HS    <= hs1;
            vga.VGA_VS    <= vs1;
            vga.VGA_BLANK <= active1;
        end
    end

    assign vga.VGA_SYNC     = 1'b0;
    assign vga.VGA_CLK      = pix_clk;
    assign vga.vblank_start = vblank;
endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout with a shortened vertical frame (16 visible of 23 lines)
// so a full frame plus reset and wrap cases fit in a short run.
module tb_vga_scanout;
    localparam int CLK_DIV = 2;
    localparam int H_ACT = 640, H_FP = 16, H_SYNC = 96, H_BP = 48;
    localparam int V_ACT = 16,  V_FP = 2,  V_SYNC = 2,  V_BP = 3;
    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int LIMIT = 2 * H_TOT * V_TOT * CLK_DIV;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ram_ones = 1'b0;
    always #10 clk = ~clk;

    vga_scanout_if bus();

    vga_scanout #(
        .CLK_DIV(CLK_DIV),
        .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .vga  (bus)
    );

    // synchronous RAM model, 1 clk read latency
    always @(posedge clk) bus.rd_data <= ram_ones ? 3'b111 : bus.rd_addr[2:0];

    int checks = 0;
    int errors = 0;

    // reference raster position and the position 2 ticks ago (what the pins show)
    int mdiv, mh, mv, d1h, d1v, d2h, d2v;
    int ticks = 0;
    bit mon_en = 1'b0;
    bit mon_done = 1'b0;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mdiv <= 0; mh <= 0; mv <= 0;
            d1h <= H_TOT - 1; d1v <= V_TOT - 1;
            d2h <= H_TOT - 1; d2v <= V_TOT - 1;
        end else if (mdiv == CLK_DIV - 1) begin
            mdiv <= 0;
            d1h <= mh; d1v <= mv; d2h <= d1h; d2v <= d1v;
            if (mh == H_TOT - 1) begin
                mh <= 0;
                mv <= (mv == V_TOT - 1) ? 0 : mv + 1;
            end else begin
                mh <= mh + 1;
            end
            if (mon_en && !mon_done) begin
                ticks <= ticks + 1;
                if (mh == H_TOT - 1 && mv == V_TOT - 1) mon_done <= 1'b1;
            end
        end else begin
            mdiv <= mdiv + 1;
        end
    end

    int hs_err = 0, vs_err = 0, blank_err = 0, rgb_err = 0, clk_err = 0, sync_err = 0;
    int vb_cnt = 0, vb_h = -1, vb_v = -1;
    logic exp_act;
    always @(negedge clk) begin
        if (mon_en && !mon_done && !reset) begin
            exp_act = (d2h < H_ACT) && (d2v < V_ACT);
            if (bus.VGA_HS !== !(d2h >= H_ACT + H_FP && d2h < H_ACT + H_FP + H_SYNC)) hs_err++;
            if (bus.VGA_VS !== !(d2v >= V_ACT + V_FP && d2v < V_ACT + V_FP + V_SYNC)) vs_err++;
            if (bus.VGA_BLANK !== exp_act) blank_err++;
            if (!exp_act && (bus.VGA_R | bus.VGA_G | bus.VGA_B) !== 10'd0) rgb_err++;
            if (bus.VGA_CLK !== (mdiv >= CLK_DIV / 2)) clk_err++;
            if (bus.VGA_SYNC !== 1'b0) sync_err++;
            if (bus.vblank_start === 1'b1) begin
                vb_cnt++; vb_h = mh; vb_v = mv;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_hv(input int h, input int v);
        int n;
        n = 0;
        while (!(mh == h && mv == v) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (!(mh == h && mv == v)) begin
            checks++;
            errors++;
            $display("FAIL wait_hv: timed out at h=%0d v=%0d waiting for h=%0d v=%0d", mh, mv, h, v);
        end
    endtask

    task automatic nxt(input int h, input int v, output int nh, output int nv);
        if (h == H_TOT - 1) begin
            nh = 0;
            nv = (v == V_TOT - 1) ? 0 : v + 1;
        end else begin
            nh = h + 1;
            nv = v;
        end
    endtask

    typedef struct {
        int         h;
        int         v;
        bit         ones;
        int         addr;
        logic [2:0] rgb;
        logic [2:0] hvb;   // {HS, VS, BLANK}
    } vec_t;

    vec_t tbl[18];

    initial begin
        int h1, v1, h2, v2;
        tbl[0]  = '{0,   0,  1'b0, 0,   3'b000, 3'b111};
        tbl[1]  = '{3,   3,  1'b0, 0,   3'b000, 3'b111};
        tbl[2]  = '{4,   4,  1'b0, 161, 3'b001, 3'b111};
        tbl[3]  = '{8,   4,  1'b0, 162, 3'b010, 3'b111};
        tbl[4]  = '{20,  8,  1'b0, 325, 3'b101, 3'b111};
        tbl[5]  = '{639, 15, 1'b0, 639, 3'b111, 3'b111};
        tbl[6]  = '{640, 15, 1'b0, 0,   3'b000, 3'b110};
        tbl[7]  = '{656, 15, 1'b0, 0,   3'b000, 3'b010};
        tbl[8]  = '{751, 15, 1'b0, 0,   3'b000, 3'b010};
        tbl[9]  = '{752, 15, 1'b0, 0,   3'b000, 3'b110};
        tbl[10] = '{0,   16, 1'b1, 0,   3'b000, 3'b110};
        tbl[11] = '{100, 18, 1'b1, 0,   3'b000, 3'b100};
        tbl[12] = '{700, 19, 1'b1, 0,   3'b000, 3'b000};
        tbl[13] = '{0,   20, 1'b1, 0,   3'b000, 3'b110};
        tbl[14] = '{799, 22, 1'b1, 0,   3'b000, 3'b110};
        tbl[15] = '{0,   0,  1'b1, 0,   3'b111, 3'b111};
        tbl[16] = '{639, 0,  1'b1, 159, 3'b111, 3'b111};
        tbl[17] = '{640, 0,  1'b1, 0,   3'b000, 3'b110};

        // power-on reset state
        repeat (3) @(negedge clk);
        chk("rst_addr", bus.rd_addr, 0);
        chk("rst_hvb", {bus.VGA_HS, bus.VGA_VS, bus.VGA_BLANK}, 3'b110);
        chk("rst_rgb", {bus.VGA_R, bus.VGA_G, bus.VGA_B}, 0);
        chk("rst_vblank", bus.vblank_start, 0);
        reset = 1'b0;

        // mid-frame reset: pins show pixel (298,5) -> addr 234 -> colour 010
        wait_hv(300, 5);
        chk("pre_reset_rgb", {bus.VGA_R, bus.VGA_G, bus.VGA_B}, {10'h000, 10'h3FF, 10'h000});
        chk("pre_reset_blank", bus.VGA_BLANK, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_hvb", {bus.VGA_HS, bus.VGA_VS, bus.VGA_BLANK}, 3'b110);
        chk("mid_rst_rgb", {bus.VGA_R, bus.VGA_G, bus.VGA_B}, 0);
        chk("mid_rst_addr", bus.rd_addr, 0);
        @(negedge clk);
        reset = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("h_after_rel0", dut.u_timing.h_cnt, 0);
        @(negedge clk);
        chk("h_after_rel1", dut.u_timing.h_cnt, 1);
        chk("v_after_rel1", dut.u_timing.v_cnt, 0);

        // address one tick after the pixel, pins two ticks after
        foreach (tbl[i]) begin
            ram_ones = tbl[i].ones;
            nxt(tbl[i].h, tbl[i].v, h1, v1);
            wait_hv(h1, v1);
            chk($sformatf("addr[%0d]", i), bus.rd_addr, tbl[i].addr);
            nxt(h1, v1, h2, v2);
            wait_hv(h2, v2);
            chk($sformatf("rgb[%0d]", i), {bus.VGA_R, bus.VGA_G, bus.VGA_B},
                {{10{tbl[i].rgb[2]}}, {10{tbl[i].rgb[1]}}, {10{tbl[i].rgb[0]}}});
            chk($sformatf("hvb[%0d]", i), {bus.VGA_HS, bus.VGA_VS, bus.VGA_BLANK}, tbl[i].hvb);
        end

        begin
            int n;
            n = 0;
            while (!mon_done && n < LIMIT) begin
                @(negedge clk);
                n++;
            end
        end
        chk("frame_done", mon_done, 1);
        chk("frame_ticks", ticks, H_TOT * V_TOT);
        chk("vblank_count", vb_cnt, 1);
        chk("vblank_line", vb_v, V_ACT);
        chk("vblank_h", vb_h, 0);
        chk("hs_frame_errs", hs_err, 0);
        chk("vs_frame_errs", vs_err, 0);
        chk("blank_frame_errs", blank_err, 0);
        chk("rgb_offscreen_errs", rgb_err, 0);
        chk("vga_clk_errs", clk_err, 0);
        chk("vga_sync_errs", sync_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Read side of the game framebuffer. The drawing controller/datapath writes (x, y, colour, plot) into a 160x120, 3-bit-per-pixel framebuffer RAM. This block reads that RAM back in raster order.
- It generates 640x480@60 Hz VGA timing and scales each framebuffer pixel 4x4.
- It drives the DAC pins and gives game logic a once-per-frame vblank pulse for safe board updates.

Parameters:
- CLK_DIV, 2, system clocks per VGA pixel (50 MHz clk gives a 25 MHz pixel rate); must be at least 2.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, horizontal sync width.
- H_BP, 48, horizontal back porch.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vertical sync width.
- V_BP, 33, vertical back porch.
- FB_W, 160, framebuffer width; FB_H is 120; scale is fixed at 4.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rd_addr  out  15  framebuffer read address, y*160+x.
- rd_data  in  3  colour {R,G,B} from the synchronous RAM, valid 1 clk after rd_addr.
- VGA_R  out  10  red DAC value, colour bit replicated.
- VGA_G  out  10  green DAC value.
- VGA_B  out  10  blue DAC value.
- VGA_HS  out  1  horizontal sync, active-low.
- VGA_VS  out  1  vertical sync, active-low.
- VGA_BLANK  out  1  active-low blank; 0 outside the visible area.
- VGA_SYNC  out  1  tied 0.
- VGA_CLK  out  1  pixel clock; high during the second half of each CLK_DIV period.
- vblank_start  out  1  one-clk pulse at the first non-visible line of each frame.

Behaviour:
- Reset values (asynchronous, on reset=1):
  - div counter, h_cnt and v_cnt are 0.
  - rd_addr is 0.
  - VGA_R, VGA_G, VGA_B are 0.
  - VGA_HS and VGA_VS are 1 (inactive).
  - VGA_BLANK is 0; vblank_start is 0.
- Reset mid-frame: outputs return to the reset values immediately; timing restarts at h=0, v=0 after release.
- pix_en:
  - Div counter runs 0..CLK_DIV-1 and wraps.
  - pix_en is 1 on the clk where div = CLK_DIV-1.
  - All pipeline and counter registers update only on pix_en.
- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = 800.
  - At the wrap, h_cnt goes to 0 and v_cnt increments.
  - v_cnt runs 0..V_TOTAL-1, where V_TOTAL = 525, then wraps to 0.
  - Wrap at 799/524 goes to 0/0 in a single pix_en.
- Stage 0 (combinational from the counters):
  - active = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE).
  - hs_n = not(H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC).
  - vs_n uses the same rule vertically.
  - fx = h_cnt[9:2], fy = v_cnt[8:2].
- Stage 1 (on pix_en):
  - rd_addr is set to fy*160 + fx, computed as (fy<<7) + (fy<<5) + fx. This is 15 bits, maximum 19199.
  - rd_addr is set to 0 when not active.
  - active, hs_n and vs_n are delayed into stage-1 registers.
- RAM: returns rd_data 1 clk later, which is guaranteed before the next pix_en because CLK_DIV >= 2.
- Stage 2 (on pix_en):
  - VGA_R = {10{rd_data[2] & active1}}, VGA_G from rd_data[1], VGA_B from rd_data[0].
  - VGA_HS = hs1, VGA_VS = vs1, VGA_BLANK = active1.
  - Total latency from counter to pins is 2 pixel ticks, identical for colour, sync and blank, so the syncs stay aligned.
- vblank_start: 1 for exactly one clk, on the pix_en where h_cnt wraps to 0 and v_cnt becomes V_ACTIVE (480).
- Colour outside the visible area is forced to 0 regardless of rd_data.

Decomposition:
- Shared package `vga_pkg`:
  - timing constants (H/V active, porch and sync widths, totals).
  - FB_W, FB_H, scale shift of 2.
  - colour encoding constants, e.g. RED = 3'b100, YELLOW = 3'b110, BLACK = 3'b000, for the drawing datapath to reuse.
- One sub-module, `vga_timing`: div counter, pix_en, h_cnt, v_cnt, active, hs_n, vs_n and vblank_start.
- `vga_scanout` adds the address pipeline and the output registers.

Test Plan:
- Reset asserted mid-line (h=300, v=100) -> next clk: VGA_HS=1, VGA_VS=1, VGA_BLANK=0, RGB=0, rd_addr=0. After release, first pix_en gives h_cnt=1.
- Free-run one frame -> VGA_HS low for 96 ticks starting at h=656 each line. VGA_VS low on v=490..491. Exactly 525*800 pix_en per frame. Exactly one vblank_start, at v=480.
- Address mapping:
  - h=0, v=0 -> rd_addr 0.
  - h=3, v=3 -> 0.
  - h=4, v=4 -> 161.
  - h=639, v=479 -> 19199.
- Model RAM: data = addr[2:0] with 1-clk latency -> pixel at h=4 shows rd_data=1, so VGA_B=10'h3FF, 2 pixel ticks after h_cnt=4. The transition coincides exactly with the 2-tick-delayed h.
- RAM forced to 3'b111 -> RGB=0 and VGA_BLANK=0 at h=640..799 and v>=480. RGB=3FF in all visible pixels.
- Wrap at h=799, v=524 -> next pix_en gives h=0, v=0, and the first visible pixel of the new frame appears on the pins 2 ticks later.
